regfile_2r1w_32x32_ctl: RTL

Sequencing and arbitration controller that sits directly in front of the predecoded 32x32 2R1W register-file macro. It accepts binary addresses from two write requesters and two independent read clients. It arbitrates the single write port, registers and predecodes all addresses into the macro's one-hot groups, and captures read data into output registers with a fixed latency. All macro-facing signals are registered, so the macro sees clean, glitch-free predecode levels for a full cycle.

---
 rtl/regfile_2r1w_32x32_ctl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/regfile_2r1w_32x32_ctl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w_32x32_ctl
// Purpose  : Sequencing / arbitration controller in front of the predecoded
//            32x32 2R1W register-file macro. Arbitrates two write requesters
//            onto the single macro write port. Registers and predecodes every
//            address into the macro's one-hot groups. Captures macro read data
//            into output registers with a fixed latency.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            wN_req/adr/dat -> wN_gnt   - write requesters 0/1 (grant is
//                                         combinational, consumes the request)
//            rdN_req/adr -> rdN_vld/q   - read clients 0/1, always accepted
//            rdN_* / wr0_* predecode    - macro-facing one-hot address groups
//            wr0_dat                    - macro write data
//            rd0_dat, rd1_dat           - macro read data (valid in the
//                                         predecode cycle)
// Params   : WR_PRIO (0 = round-robin, 1 = w0 fixed priority)
//            RD_LAT  (2 or 3 cycles from rdN_req to rdN_vld)
// Options  : REGFILE_CTL_BYPASS_EN - forward the in-flight write data to a
//            read of the same address in the same predecode cycle.
// Address  : the 5-bit address is numbered a0..a4 with a0 the MSB, so
//            a0 = adr[4] ... a4 = adr[0].
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w_32x32_ctl #(
    parameter int WR_PRIO = 0,
    parameter int RD_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w0_req,
    input  logic [4:0]  w0_adr,
    input  logic [31:0] w0_dat,
    output logic        w0_gnt,
    input  logic        w1_req,
    input  logic [4:0]  w1_adr,
    input  logic [31:0] w1_dat,
    output logic        w1_gnt,
    input  logic        rd0_req,
    input  logic [4:0]  rd0_adr,
    output logic        rd0_vld,
    output logic [31:0] rd0_q,
    input  logic        rd1_req,
    input  logic [4:0]  rd1_adr,
    output logic        rd1_vld,
    output logic [31:0] rd1_q,
    output logic        rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2,
    output logic        rd0_a1_a2, rd0_na3, rd0_a3, rd0_na4, rd0_a4,
    output logic        rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2,
    output logic        rd1_a1_a2, rd1_na3, rd1_a3, rd1_na4, rd1_a4,
    output logic        wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2,
    output logic        wr0_a1_a2, wr0_na3, wr0_a3, wr0_na4, wr0_a4,
    output logic [31:0] wr0_dat,
    input  logic [31:0] rd0_dat,
    input  logic [31:0] rd1_dat
);

    // Predecode vector layout, MSB first:
    // {c_na0, c_a0, na1_na2, na1_a2, a1_na2, a1_a2, na3, a3, na4, a4}
    function automatic logic [9:0] f_predecode(input logic en, input logic [4:0] adr);
        logic a0, a1, a2, a3, a4;
        a0 = adr[4];
        a1 = adr[3];
        a2 = adr[2];
        a3 = adr[1];
        a4 = adr[0];
        f_predecode = {en & ~a0, en & a0,
                       en & ~a1 & ~a2, en & ~a1 & a2, en & a1 & ~a2, en & a1 & a2,
                       en & ~a3, en & a3, en & ~a4, en & a4};
    endfunction

    // ------------------------------------------------------------------
    // Write arbitration
    // ------------------------------------------------------------------
    logic        r_rr_ptr;      // 0: w0 wins the next contention, 1: w1 wins
    logic        w_gnt0;
    logic        w_gnt1;
    logic [9:0]  r_wr_pd;
    logic [31:0] r_wr_dat;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (w0_req && w1_req) begin
                if ((WR_PRIO != 0) || !r_rr_ptr) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = w0_req;
                w_gnt1 = w1_req;
            end
        end
    end

    assign w0_gnt = w_gnt0;
    assign w1_gnt = w_gnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
            r_wr_pd  <= '0;
            r_wr_dat <= '0;
        end else begin
            if (w_gnt0) begin
                r_rr_ptr <= 1'b1;
            end else if (w_gnt1) begin
                r_rr_ptr <= 1'b0;
            end
            r_wr_pd  <= f_predecode(w_gnt0 | w_gnt1, w_gnt0 ? w0_adr : w1_adr);
            r_wr_dat <= w_gnt0 ? w0_dat : (w_gnt1 ? w1_dat : 32'h0);
        end
    end

    // A write already in its predecode cycle when reset arrives must not reach
    // the array, so reset masks the registered write group at the macro.
    logic [9:0]  w_wr_pd;
    assign w_wr_pd = r_wr_pd & {10{~reset}};
    assign wr0_dat = r_wr_dat & {32{~reset}};

    assign {wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2,
            wr0_a1_a2, wr0_na3, wr0_a3, wr0_na4, wr0_a4} = w_wr_pd;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic        w_rd_req [2];
    logic [4:0]  w_rd_adr [2];
    logic [31:0] w_rd_dat [2];
    logic [9:0]  w_rd_pd  [2];
    logic        w_rd_vld [2];
    logic [31:0] w_rd_q   [2];

    assign w_rd_req[0] = rd0_req;
    assign w_rd_req[1] = rd1_req;
    assign w_rd_adr[0] = rd0_adr;
    assign w_rd_adr[1] = rd1_adr;
    assign w_rd_dat[0] = rd0_dat;
    assign w_rd_dat[1] = rd1_dat;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_rd_port
            logic [9:0]  r_pd;
            logic        r_vld1;
            logic [31:0] r_q1;
            logic        w_act;
            logic [31:0] w_cap;

            // The a0 pair is one-hot whenever the port is enabled.
            assign w_act = r_pd[9] | r_pd[8];

`ifdef REGFILE_CTL_BYPASS_EN
            // Identical enabled predecode vectors mean identical addresses.
            assign w_cap = (w_act && (r_pd == r_wr_pd)) ? r_wr_dat : w_rd_dat[gi];
`else
            assign w_cap = w_rd_dat[gi];
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pd   <= '0;
                    r_vld1 <= 1'b0;
                    r_q1   <= '0;
                end else begin
                    r_pd   <= f_predecode(w_rd_req[gi], w_rd_adr[gi]);
                    r_vld1 <= w_act;
                    if (w_act) begin
                        r_q1 <= w_cap;
                    end
                end
            end

            assign w_rd_pd[gi] = r_pd;

            if (RD_LAT == 3) begin : g_lat3
                logic        r_vld2;
                logic [31:0] r_q2;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_vld2 <= 1'b0;
                        r_q2   <= '0;
                    end else begin
                        r_vld2 <= r_vld1;
                        if (r_vld1) begin
                            r_q2 <= r_q1;
                        end
                    end
                end
                assign w_rd_vld[gi] = r_vld2;
                assign w_rd_q[gi]   = r_q2;
            end else begin : g_lat2
                assign w_rd_vld[gi] = r_vld1;
                assign w_rd_q[gi]   = r_q1;
            end
        end
    endgenerate

    assign {rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2,
            rd0_a1_a2, rd0_na3, rd0_a3, rd0_na4, rd0_a4} = w_rd_pd[0];
    assign {rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2,
            rd1_a1_a2, rd1_na3, rd1_a3, rd1_na4, rd1_a4} = w_rd_pd[1];

    assign rd0_vld = w_rd_vld[0];
    assign rd0_q   = w_rd_q[0];
    assign rd1_vld = w_rd_vld[1];
    assign rd1_q   = w_rd_q[1];

endmodule
`default_nettype wire
